// File: rtl/i2s_rx_if.sv
// I2S receive port bundle: serial data in; bit clock, word select and the
// assembled stereo frame out.
interface i2s_rx_if;
   // No valid/ready here: rx_data is a level that is always valid and changes
   // only when a frame completes; consumers watch for a ws fall or a value change.
   logic        rx;
   logic        ws;
   logic        i2s_clk;
   logic [63:0] rx_data;

   // master: the receiver, which also generates the bit clock and word select.
   modport master (input rx, output ws, output i2s_clk, output rx_data);
   // slave: the transmitter side (or a bench acting as one).
   modport slave  (output rx, input ws, input i2s_clk, input rx_data);
endinterface

// File: rtl/i2s_rx.sv
// I2S master receiver: divides clk into i2s_clk, captures rx on each i2s_clk
// fall and publishes two 24-bit samples per 64-bit frame.
module i2s_rx #(
   parameter int unsigned DIV_HALF = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   i2s_rx_if.master bus
);

   localparam logic [7:0] DIV_LAST = 8'(DIV_HALF - 1);

   logic [7:0]  r_div;
   logic        r_i2s_clk;
   logic        r_ws;
   logic [5:0]  r_bit;
   logic [63:0] r_shift;
   logic [63:0] r_rx_data;

   logic        w_wrap;
   logic        w_sample;
   logic [5:0]  w_bit_nxt;
   logic [63:0] w_shift_nxt;

   assign w_wrap      = (r_div == DIV_LAST);
   // A wrap while i2s_clk is high is the falling edge, where rx is stable.
   assign w_sample    = w_wrap & r_i2s_clk;
   assign w_bit_nxt   = r_bit + 6'd1;
   assign w_shift_nxt = {bus.rx, r_shift[63:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div     <= 8'd0;
         r_i2s_clk <= 1'b0;
         r_ws      <= 1'b0;
         r_bit     <= 6'd0;
         r_shift   <= 64'd0;
         r_rx_data <= 64'd0;
      end else begin
         r_div <= w_wrap ? 8'd0 : r_div + 8'd1;
         if (w_wrap) begin
            r_i2s_clk <= ~r_i2s_clk;
         end
         if (w_sample) begin
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_ws    <= w_bit_nxt[5];
            // Bit 63 completes the frame; keep the low 24 bits of each slot.
            if (r_bit == 6'd63) begin
               r_rx_data <= {8'h00, w_shift_nxt[55:32], 8'h00, w_shift_nxt[23:0]};
            end
         end
      end
   end

   assign bus.i2s_clk = r_i2s_clk;
   assign bus.ws      = r_ws;
   assign bus.rx_data = r_rx_data;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed + random bench for i2s_rx acting as an LSB-first I2S transmitter,
// with a frame-level reference model of the expected rx_data and ws.
module tb_i2s_rx;

   localparam int unsigned DIV_HALF = 4;
   localparam int          TMO      = 4 * DIV_HALF + 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   i2s_rx_if bus ();

   i2s_rx #(.DIV_HALF(DIV_HALF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   logic [63:0] exp_q[$];     // history of expected rx_data values, newest last
   logic [63:0] cur_frame;
   int          n_bits;
   logic        exp_ws;

   function automatic logic [63:0] fmt_frame(input logic [63:0] f);
      return {8'h00, f[55:32], 8'h00, f[23:0]};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      exp_q.push_back(64'd0);
      cur_frame = 64'd0;
      n_bits    = 0;
      exp_ws    = 1'b0;
   endtask

   task automatic model_sample(input logic b);
      cur_frame[n_bits] = b;
      n_bits = n_bits + 1;
      if (n_bits == 64) begin
         exp_q.push_back(fmt_frame(cur_frame));
         n_bits = 0;
      end
      exp_ws = (n_bits >= 32);
   endtask

   // ---------------- checker ----------------
   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Waits (bounded) until i2s_clk reaches lvl; n = clk edges spent.
   task automatic wait_level(input logic lvl, output int n);
      n = 0;
      while (bus.i2s_clk !== lvl && n < TMO) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic send_frame(input logic [63:0] w, input int nbits);
      int n;
      for (int i = 0; i < nbits; i++) begin
         wait_level(1'b1, n);
         check64("rise_delay", 64'(n), 64'(DIV_HALF));
         check64("ws_at_rise", 64'(bus.ws), 64'(exp_ws));
         bus.rx = w[i];
         wait_level(1'b0, n);
         check64("fall_delay", 64'(n), 64'(DIV_HALF));
         model_sample(w[i]);
         check64("ws_at_fall", 64'(bus.ws), 64'(exp_ws));
         check64("rx_data_hold", bus.rx_data, exp_q[$]);
      end
   endtask

   // Holds reset for 'cycles' clk edges, checks cleared outputs, releases.
   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      check64("rst_rx_data", bus.rx_data, 64'd0);
      check64("rst_ws", 64'(bus.ws), 64'd0);
      check64("rst_i2s_clk", 64'(bus.i2s_clk), 64'd0);
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [63:0] rnd;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      bus.rx   = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      do_reset(3);

      send_frame(64'h55667788ABCDEFAB, 64);
      check64("frame_a", bus.rx_data, 64'h0066778800CDEFAB);

      send_frame(64'h22334455FBABABAB, 64);
      check64("frame_b", bus.rx_data, 64'h0033445500ABABAB);
      send_frame(64'hBABABABA55667788, 64);
      check64("frame_c", bus.rx_data, 64'h00BABABA00667788);

      send_frame(64'hFFFFFFFFFFFFFFFF, 64);
      check64("all_ones", bus.rx_data, 64'h00FFFFFF00FFFFFF);
      send_frame(64'h0000000000000000, 64);
      check64("all_zeros", bus.rx_data, 64'd0);

      for (int k = 0; k < 4; k++) begin
         rnd = {$urandom, $urandom};
         send_frame(rnd, 64);
         check64("random_frame", bus.rx_data, fmt_frame(rnd));
      end

      send_frame(64'h0123456789ABCDEF, 20);
      @(posedge clk);
      #1;
      do_reset(1);
      send_frame(64'h55667788ABCDEFAB, 64);
      check64("after_mid_reset", bus.rx_data, 64'h0066778800CDEFAB);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
